// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS register file slice
package mips_pkg;

    localparam int MIPS_DATA_W = 32;
    localparam int MIPS_ADDR_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } regfile_clr_state_t;

endpackage

// File: rtl/mips_regfile_sb_if.sv
// rtl/mips_regfile_sb_if.sv - decode/writeback bus into the register file
interface mips_regfile_sb_if
    import mips_pkg::*;
#(
    parameter int DATA_W = MIPS_DATA_W,
    parameter int ADDR_W = MIPS_ADDR_W
) ();

    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_dst;
    logic              pend1;
    logic              pend2;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output we, wa, wd, ra1, ra2, iss_valid, iss_dst, clr_req,
        input  rd1, rd2, pend1, pend2, clr_busy, clr_done
    );

    modport slave (
        input  we, wa, wd, ra1, ra2, iss_valid, iss_dst, clr_req,
        output rd1, rd2, pend1, pend2, clr_busy, clr_done
    );

endinterface

// File: rtl/mips_scoreboard.sv
// rtl/mips_scoreboard.sv - per-register pending bits with set/clear and two lookups
module mips_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_W = MIPS_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_idx_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_idx_i,
    input  logic [ADDR_W-1:0] lk1_idx_i,
    input  logic [ADDR_W-1:0] lk2_idx_i,
    output logic              lk1_pend_o,
    output logic              lk2_pend_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // Next pending vector: clear first so a same-index set overrides it
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) begin
            pend_d[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            pend_d[set_idx_i] = 1'b1;
        end
    end

    // Pending bit storage
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign lk1_pend_o = pend_q[lk1_idx_i];
    assign lk2_pend_o = pend_q[lk2_idx_i];

endmodule

// File: rtl/mips_regfile_sb.sv
// rtl/mips_regfile_sb.sv - register file with bypass, scoreboard and clear engine
module mips_regfile_sb
    import mips_pkg::*;
#(
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int ADDR_W   = MIPS_ADDR_W,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             reset_b,
    mips_regfile_sb_if.slave rf
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    regfile_clr_state_t state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               done_q, done_d;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q;

    logic              clr_busy;
    logic              wr_legal;
    logic              iss_legal;
    logic              byp1;
    logic              byp2;
    logic              sb_pend1;
    logic              sb_pend2;
    logic              sb_clr_en;
    logic [ADDR_W-1:0] sb_clr_idx;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    assign clr_busy  = (state_q == CLEAR);
    assign wr_legal  = rf.we && !clr_busy && !(ZERO_REG && (rf.wa == '0));
    assign iss_legal = rf.iss_valid && !clr_busy && !(ZERO_REG && (rf.iss_dst == '0));

    // wr_legal already excludes the clear window, so bypass is naturally off then
    assign byp1 = BYPASS && wr_legal && (rf.wa == rf.ra1);
    assign byp2 = BYPASS && wr_legal && (rf.wa == rf.ra2);

    // Clear engine next state: walk every index once, pulse done on the way out
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rf.clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Clear engine state register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    // Storage: the clear engine owns the write port while busy
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mem_q <= '0;
        end else if (clr_busy) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_legal) begin
            mem_q[rf.wa] <= rf.wd;
        end
    end

    // Read port 1: array, then same-cycle forward, then hardwired zero
    always_comb begin
        rd1 = mem_q[rf.ra1];
        if (byp1) begin
            rd1 = rf.wd;
        end
        if (ZERO_REG && (rf.ra1 == '0)) begin
            rd1 = '0;
        end
    end

    // Read port 2: same priority as port 1
    always_comb begin
        rd2 = mem_q[rf.ra2];
        if (byp2) begin
            rd2 = rf.wd;
        end
        if (ZERO_REG && (rf.ra2 == '0)) begin
            rd2 = '0;
        end
    end

    // The scoreboard clear port is shared between writeback and the clear walk
    assign sb_clr_en  = clr_busy || wr_legal;
    assign sb_clr_idx = clr_busy ? ptr_q : rf.wa;

    mips_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset_b    (reset_b),
        .set_en_i   (iss_legal),
        .set_idx_i  (rf.iss_dst),
        .clr_en_i   (sb_clr_en),
        .clr_idx_i  (sb_clr_idx),
        .lk1_idx_i  (rf.ra1),
        .lk2_idx_i  (rf.ra2),
        .lk1_pend_o (sb_pend1),
        .lk2_pend_o (sb_pend2)
    );

    assign rf.rd1      = rd1;
    assign rf.rd2      = rd2;
    assign rf.pend1    = sb_pend1 && !byp1;
    assign rf.pend2    = sb_pend2 && !byp2;
    assign rf.clr_busy = clr_busy;
    assign rf.clr_done = done_q;

endmodule

// File: tb/tb_mips_regfile_sb.sv
// tb/tb_mips_regfile_sb.sv - self-checking bench for mips_regfile_sb
module tb_mips_regfile_sb;

    logic clk     = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    logic        t_we, t_iv, t_clr;
    logic [4:0]  t_wa, t_ra1, t_ra2, t_idst;
    logic [31:0] t_wd;
    logic        s_we, s_iv, s_clr;
    logic [2:0]  s_wa, s_ra1, s_ra2, s_idst;
    logic [15:0] s_wd;

    mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifa ();
    mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) ifn ();
    mips_regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) ifs ();

    assign ifa.we = t_we;   assign ifa.wa = t_wa;   assign ifa.wd = t_wd;
    assign ifa.ra1 = t_ra1; assign ifa.ra2 = t_ra2; assign ifa.iss_valid = t_iv;
    assign ifa.iss_dst = t_idst; assign ifa.clr_req = t_clr;
    assign ifn.we = t_we;   assign ifn.wa = t_wa;   assign ifn.wd = t_wd;
    assign ifn.ra1 = t_ra1; assign ifn.ra2 = t_ra2; assign ifn.iss_valid = t_iv;
    assign ifn.iss_dst = t_idst; assign ifn.clr_req = t_clr;
    assign ifs.we = s_we;   assign ifs.wa = s_wa;   assign ifs.wd = s_wd;
    assign ifs.ra1 = s_ra1; assign ifs.ra2 = s_ra2; assign ifs.iss_valid = s_iv;
    assign ifs.iss_dst = s_idst; assign ifs.clr_req = s_clr;

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .reset_b(reset_b), .rf(ifa));
    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
        .clk(clk), .reset_b(reset_b), .rf(ifn));
    mips_regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_s (
        .clk(clk), .reset_b(reset_b), .rf(ifs));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_a();
        t_we = 1'b0; t_wa = '0; t_wd = '0; t_ra1 = '0; t_ra2 = '0;
        t_iv = 1'b0; t_idst = '0; t_clr = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1, ra2;
        logic        iv;
        logic [4:0]  idst;
        logic [31:0] a_rd1, a_rd2;
        logic        a_p1, a_p2;
        logic [31:0] n_rd1, n_rd2;
        logic        n_p1, n_p2;
    } vec_t;

    vec_t tbl [13];

    // Reference model: architectural contents and pending flags
    logic [31:0] m_mem  [32];
    bit          m_pend [32];

    function automatic logic [31:0] m_rd(input logic [4:0] ra, input bit byp);
        if (ra == 5'd0) return 32'd0;
        if (byp && t_we && t_wa == ra) return t_wd;
        return m_mem[ra];
    endfunction

    function automatic bit m_pd(input logic [4:0] ra, input bit byp);
        if (ra == 5'd0) return 1'b0;
        if (byp && t_we && t_wa == ra) return 1'b0;
        return m_pend[ra];
    endfunction

    task automatic m_tick();
        if (t_we && t_wa != 5'd0) begin
            m_mem[t_wa]  = t_wd;
            m_pend[t_wa] = 1'b0;
        end
        if (t_iv && t_idst != 5'd0) m_pend[t_idst] = 1'b1;
    endtask

    initial begin
        int busy_cnt;
        zero_a();
        s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra1 = '0; s_ra2 = '0;
        s_iv = 1'b0; s_idst = '0; s_clr = 1'b0;

        //              we    wa     wd              ra1    ra2    iv    idst   a_rd1           a_rd2           ap1   ap2   n_rd1           n_rd2           np1   np2
        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0, 5'd0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b0, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tbl[2]  = '{1'b1, 5'd0, 32'h1234,     5'd0, 5'd5, 1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7, 1'b0, 5'd0, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd7, 1'b1, 5'd3, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        32'hA5A5A5A5, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 1'b0, 5'd0, 32'h0,        32'h0,        1'b1, 1'b1, 32'h0,        32'h0,        1'b1, 1'b1};
        tbl[6]  = '{1'b1, 5'd3, 32'h33,       5'd3, 5'd3, 1'b0, 5'd0, 32'h33,       32'h33,       1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b1};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 1'b0, 5'd0, 32'h33,       32'h33,       1'b0, 1'b0, 32'h33,       32'h33,       1'b0, 1'b0};
        tbl[8]  = '{1'b1, 5'd3, 32'h44,       5'd3, 5'd3, 1'b1, 5'd3, 32'h44,       32'h44,       1'b0, 1'b0, 32'h33,       32'h33,       1'b0, 1'b0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd3, 1'b0, 5'd0, 32'h44,       32'h44,       1'b1, 1'b1, 32'h44,       32'h44,       1'b1, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd3, 1'b1, 5'd0, 32'h0,        32'h44,       1'b0, 1'b1, 32'h0,        32'h44,       1'b0, 1'b1};
        tbl[11] = '{1'b1, 5'd3, 32'h55,       5'd0, 5'd3, 1'b0, 5'd0, 32'h0,        32'h55,       1'b0, 1'b0, 32'h0,        32'h44,       1'b0, 1'b1};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd3, 1'b0, 5'd0, 32'h0,        32'h55,       1'b0, 1'b0, 32'h0,        32'h55,       1'b0, 1'b0};

        // Reset state
        t_ra1 = 5'd5; t_ra2 = 5'd9;
        #2;
        chk("reset rd1", 64'(ifa.rd1), 64'd0);
        chk("reset rd2", 64'(ifa.rd2), 64'd0);
        chk("reset pend1", 64'(ifa.pend1), 64'd0);
        chk("reset pend2", 64'(ifa.pend2), 64'd0);
        chk("reset clr_busy", 64'(ifa.clr_busy), 64'd0);
        chk("reset clr_done", 64'(ifa.clr_done), 64'd0);
        @(negedge clk);
        reset_b = 1'b1;
        cyc();

        // Directed vectors on bypass and non-bypass instances
        for (int k = 0; k < 13; k++) begin
            t_we = tbl[k].we; t_wa = tbl[k].wa; t_wd = tbl[k].wd;
            t_ra1 = tbl[k].ra1; t_ra2 = tbl[k].ra2;
            t_iv = tbl[k].iv; t_idst = tbl[k].idst;
            @(negedge clk);
            chk($sformatf("vec%0d a_rd1", k), 64'(ifa.rd1), 64'(tbl[k].a_rd1));
            chk($sformatf("vec%0d a_rd2", k), 64'(ifa.rd2), 64'(tbl[k].a_rd2));
            chk($sformatf("vec%0d a_pend1", k), 64'(ifa.pend1), 64'(tbl[k].a_p1));
            chk($sformatf("vec%0d a_pend2", k), 64'(ifa.pend2), 64'(tbl[k].a_p2));
            chk($sformatf("vec%0d n_rd1", k), 64'(ifn.rd1), 64'(tbl[k].n_rd1));
            chk($sformatf("vec%0d n_rd2", k), 64'(ifn.rd2), 64'(tbl[k].n_rd2));
            chk($sformatf("vec%0d n_pend1", k), 64'(ifn.pend1), 64'(tbl[k].n_p1));
            chk($sformatf("vec%0d n_pend2", k), 64'(ifn.pend2), 64'(tbl[k].n_p2));
            cyc();
        end
        zero_a();

        // Fill r1..r31 and mark each pending, then clear the whole file
        for (int i = 1; i < 32; i++) begin
            t_we = 1'b1; t_wa = 5'(i); t_wd = 32'h1000_0000 + 32'(i);
            t_iv = 1'b1; t_idst = 5'(i);
            cyc();
        end
        zero_a();
        t_ra1 = 5'd9; t_ra2 = 5'd31;
        @(negedge clk);
        chk("fill rd r9", 64'(ifa.rd1), 64'h1000_0009);
        chk("fill rd r31", 64'(ifa.rd2), 64'h1000_001F);
        chk("fill pend r9", 64'(ifa.pend1), 64'd1);
        chk("fill pend r31", 64'(ifa.pend2), 64'd1);
        t_clr = 1'b1; t_ra2 = 5'd2;
        cyc();
        t_clr = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) begin
                t_we = 1'b1; t_wa = 5'd9; t_wd = 32'hFFFF_FFFF; t_iv = 1'b1; t_idst = 5'd2;
            end else begin
                t_we = 1'b0; t_iv = 1'b0;
            end
            @(negedge clk);
            if (!ifa.clr_busy) break;
            busy_cnt++;
            if (c == 5) begin
                chk("mid-clear no bypass rd1", 64'(ifa.rd1), 64'h1000_0009);
                chk("mid-clear pend1 unmasked", 64'(ifa.pend1), 64'd1);
                chk("mid-clear cleared r2", 64'(ifa.rd2), 64'd0);
            end
            cyc();
        end
        zero_a();
        chk("clear busy cycles", 64'(busy_cnt), 64'd32);
        chk("clr_done after clear", 64'(ifa.clr_done), 64'd1);
        cyc();
        @(negedge clk);
        chk("clr_done one cycle", 64'(ifa.clr_done), 64'd0);
        chk("idle after clear", 64'(ifa.clr_busy), 64'd0);
        for (int i = 0; i < 32; i++) begin
            cyc();
            t_ra1 = 5'(i); t_ra2 = 5'(i);
            @(negedge clk);
            chk($sformatf("post-clear rd r%0d", i), 64'(ifa.rd1), 64'd0);
            chk($sformatf("post-clear pend r%0d", i), 64'(ifa.pend1), 64'd0);
            chk($sformatf("post-clear n rd r%0d", i), 64'(ifn.rd2), 64'd0);
        end
        cyc();
        zero_a();

        // Narrow instance: 16-bit data, 8 entries, held clear request restarts
        s_we = 1'b1; s_wa = 3'd7; s_wd = 16'hBEEF;
        cyc();
        s_we = 1'b0; s_ra1 = 3'd7;
        @(negedge clk);
        chk("small r7 readback", 64'(ifs.rd1), 64'hBEEF);
        cyc();
        s_clr = 1'b1;
        cyc();
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!ifs.clr_busy) break;
            busy_cnt++;
            cyc();
        end
        chk("small busy cycles", 64'(busy_cnt), 64'd8);
        chk("small clr_done", 64'(ifs.clr_done), 64'd1);
        chk("small r7 cleared", 64'(ifs.rd1), 64'd0);
        cyc();
        @(negedge clk);
        chk("small held req restarts", 64'(ifs.clr_busy), 64'd1);
        s_clr = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            @(negedge clk);
            if (!ifs.clr_busy) break;
            busy_cnt++;
        end
        chk("small second clear length", 64'(busy_cnt), 64'd7);
        chk("small second clr_done", 64'(ifs.clr_done), 64'd1);
        cyc();

        // Asynchronous reset in the middle of a clear
        t_we = 1'b1; t_wa = 5'd5; t_wd = 32'h77; t_iv = 1'b1; t_idst = 5'd20;
        cyc();
        zero_a();
        t_ra1 = 5'd5; t_ra2 = 5'd20; t_clr = 1'b1;
        cyc();
        t_clr = 1'b0;
        cyc(); cyc(); cyc();
        chk("pre-reset busy", 64'(ifa.clr_busy), 64'd1);
        chk("pre-reset r5", 64'(ifa.rd1), 64'h77);
        chk("pre-reset pend r20", 64'(ifa.pend2), 64'd1);
        #2;
        reset_b = 1'b0;
        #1;
        chk("async reset rd1", 64'(ifa.rd1), 64'd0);
        chk("async reset pend2", 64'(ifa.pend2), 64'd0);
        chk("async reset busy", 64'(ifa.clr_busy), 64'd0);
        @(negedge clk);
        reset_b = 1'b1;
        cyc();
        @(negedge clk);
        chk("after reset idle", 64'(ifa.clr_busy), 64'd0);
        chk("after reset no done", 64'(ifa.clr_done), 64'd0);
        cyc();

        // Randomized traffic against the reference model
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        for (int it = 0; it < 400; it++) begin
            t_we   = ($urandom_range(0, 1) == 0);
            t_wa   = 5'($urandom_range(0, 31));
            t_wd   = $urandom;
            t_ra1  = ($urandom_range(0, 3) == 0) ? t_wa : 5'($urandom_range(0, 31));
            t_ra2  = ($urandom_range(0, 3) == 0) ? t_wa : 5'($urandom_range(0, 31));
            t_iv   = ($urandom_range(0, 2) == 0);
            t_idst = ($urandom_range(0, 3) == 0) ? t_wa : 5'($urandom_range(0, 31));
            @(negedge clk);
            chk("rand a_rd1", 64'(ifa.rd1), 64'(m_rd(t_ra1, 1'b1)));
            chk("rand a_rd2", 64'(ifa.rd2), 64'(m_rd(t_ra2, 1'b1)));
            chk("rand a_pend1", 64'(ifa.pend1), 64'(m_pd(t_ra1, 1'b1)));
            chk("rand a_pend2", 64'(ifa.pend2), 64'(m_pd(t_ra2, 1'b1)));
            chk("rand n_rd1", 64'(ifn.rd1), 64'(m_rd(t_ra1, 1'b0)));
            chk("rand n_pend2", 64'(ifn.pend2), 64'(m_pd(t_ra2, 1'b0)));
            m_tick();
            cyc();
        end
        zero_a();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
